// File: rtl/regfile_access_seq.sv
// Request sequencer for the 16-bit register file: word-level WRITE/READ/INC/DEC onto byte-wide file ports.
// Optional feature macro REGSEQ_RESP_HOLD_EN adds rsp_ready backpressure on the response.
module regfile_access_seq #(
    parameter int NUM_REGS = 5,
    parameter int PC_INDEX = 4
) (
    input  logic        clock,
    input  logic        reset,
`ifdef REGSEQ_RESP_HOLD_EN
    input  logic        rsp_ready,
`endif
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_reg,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    input  logic [15:0] rf_data_in,
    output logic [7:0]  rf_data_out,
    output logic [4:0]  rf_rn_in,
    output logic [4:0]  rf_rn_out,
    output logic        rf_we,
    output logic        rf_change_pc,
    output logic        rf_inc_pc
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;
    localparam logic [2:0] PC_IDX   = 3'(PC_INDEX);
    localparam logic [3:0] REG_LIM  = 4'(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR_LO,
        WR_HI,
        PC_STEP,
        RESP
    } state_t;

    state_t      state, next_state;
    logic [1:0]  op_q;
    logic [2:0]  reg_q;
    logic [15:0] value_q, value_next;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        next_state   = state;
        value_next   = value_q;
        rf_data_out  = 8'h00;
        rf_rn_in     = 5'b00000;
        rf_rn_out    = 5'b00000;
        rf_we        = 1'b0;
        rf_change_pc = 1'b0;
        rf_inc_pc    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if ({1'b0, req_reg} >= REG_LIM) begin
                        next_state = RESP;
                        value_next = 16'h0000;
                    end else begin
                        case (req_op)
                            OP_WRITE: begin
                                next_state = WR_LO;
                                value_next = req_data;
                            end
                            OP_READ: next_state = FETCH;
                            default: next_state = (req_reg == PC_IDX) ? PC_STEP : FETCH;
                        endcase
                    end
                end
            end
            FETCH: begin
                rf_rn_out = {2'b10, reg_q};
                case (op_q)
                    OP_INC: begin
                        value_next = rf_data_in + 16'd1;
                        next_state = WR_LO;
                    end
                    OP_DEC: begin
                        value_next = rf_data_in - 16'd1;
                        next_state = WR_LO;
                    end
                    default: begin
                        value_next = rf_data_in;
                        next_state = RESP;
                    end
                endcase
            end
            WR_LO: begin
                rf_we       = 1'b1;
                rf_rn_in    = {2'b00, reg_q};
                rf_data_out = value_q[7:0];
                next_state  = WR_HI;
            end
            WR_HI: begin
                rf_we       = 1'b1;
                rf_rn_in    = {2'b01, reg_q};
                rf_data_out = value_q[15:8];
                next_state  = RESP;
            end
            PC_STEP: begin
                rf_we        = 1'b1;
                rf_change_pc = 1'b1;
                rf_inc_pc    = (op_q == OP_INC);
                rf_rn_out    = {2'b10, PC_IDX};
                value_next   = (op_q == OP_INC) ? rf_data_in + 16'd1 : rf_data_in - 16'd1;
                next_state   = RESP;
            end
            RESP: begin
`ifdef REGSEQ_RESP_HOLD_EN
                if (rsp_ready)
                    next_state = IDLE;
`else
                next_state = IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
        // A reset cycle must not let a pending write reach the file (half-written register stays as-is).
        if (!reset) begin
            rf_data_out  = 8'h00;
            rf_rn_in     = 5'b00000;
            rf_rn_out    = 5'b00000;
            rf_we        = 1'b0;
            rf_change_pc = 1'b0;
            rf_inc_pc    = 1'b0;
        end
    end

    // The only IDLE->RESP path is the bad-register one, so that transition alone sets rsp_err.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            op_q     <= 2'b00;
            reg_q    <= 3'b000;
            value_q  <= 16'h0000;
            rsp_data <= 16'h0000;
            rsp_err  <= 1'b0;
        end else begin
            state   <= next_state;
            value_q <= value_next;
            if (state == IDLE && req_valid) begin
                op_q  <= req_op;
                reg_q <= req_reg;
            end
            if (next_state == RESP && state != RESP) begin
                rsp_data <= value_next;
                rsp_err  <= (state == IDLE);
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_seq.sv
// Directed bench for regfile_access_seq with a behavioural register-file model on the rf_* ports.
// Define REGSEQ_RESP_HOLD_EN to also exercise response backpressure.
module tb_regfile_access_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [2:0]  req_reg = 3'b000;
    logic [15:0] req_data = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [15:0] rf_data_in;
    logic [7:0]  rf_data_out;
    logic [4:0]  rf_rn_in;
    logic [4:0]  rf_rn_out;
    logic        rf_we;
    logic        rf_change_pc;
    logic        rf_inc_pc;
`ifdef REGSEQ_RESP_HOLD_EN
    logic        rsp_ready = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int         lat;
    int         we_cnt;
    int         cpc_cnt;
    logic [4:0] w_rn [4];
    logic [7:0] w_dat [4];
    logic [4:0] rn_out_seen;
    logic       inc_seen;

    // Register file model: BC, DE, HL, SP, PC initial contents.
    logic [15:0] file [8] = '{16'hFFFF, 16'h0000, 16'h1234, 16'h0000, 16'h0100,
                              16'h0000, 16'h0000, 16'h0000};

    regfile_access_seq dut (
        .clock(clock),
        .reset(reset),
`ifdef REGSEQ_RESP_HOLD_EN
        .rsp_ready(rsp_ready),
`endif
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_reg(req_reg),
        .req_data(req_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .rf_data_in(rf_data_in),
        .rf_data_out(rf_data_out),
        .rf_rn_in(rf_rn_in),
        .rf_rn_out(rf_rn_out),
        .rf_we(rf_we),
        .rf_change_pc(rf_change_pc),
        .rf_inc_pc(rf_inc_pc)
    );

    always #5 clock = ~clock;

    assign rf_data_in = file[rf_rn_out[2:0]];

    always @(posedge clock) begin
        if (rf_we) begin
            if (rf_change_pc)
                file[4] <= rf_inc_pc ? file[4] + 16'd1 : file[4] - 16'd1;
            else if (rf_rn_in[3])
                file[rf_rn_in[2:0]][15:8] <= rf_data_out;
            else
                file[rf_rn_in[2:0]][7:0] <= rf_data_out;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request from a negedge in IDLE and records file-port activity until the response.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] rg, input logic [15:0] d);
        we_cnt      = 0;
        cpc_cnt     = 0;
        rn_out_seen = 5'b00000;
        inc_seen    = 1'b0;
        lat         = -1;
        checkOutput("ready_before", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_reg   = rg;
        req_data  = d;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op    = ~op;
        req_data  = ~d;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (rf_we) begin
                if (we_cnt < 4) begin
                    w_rn[we_cnt]  = rf_rn_in;
                    w_dat[we_cnt] = rf_data_out;
                end
                we_cnt++;
            end
            if (rf_change_pc) begin
                cpc_cnt++;
                inc_seen = rf_inc_pc;
            end
            if (rf_rn_out != 5'b00000)
                rn_out_seen = rf_rn_out;
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clock);
            checkOutput("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
            checkOutput("ready_after", {31'b0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_data", {16'b0, rsp_data}, 32'h0);
        checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("rst_rf_we", {31'b0, rf_we}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // WRITE16 DE=BEEF
        applyStimulus(2'b00, 3'd1, 16'hBEEF);
        checkOutput("wr_lat", lat, 32'd3);
        checkOutput("wr_we_cnt", we_cnt, 32'd2);
        checkOutput("wr_lo_rn", {27'b0, w_rn[0]}, 32'h01);
        checkOutput("wr_lo_dat", {24'b0, w_dat[0]}, 32'hEF);
        checkOutput("wr_hi_rn", {27'b0, w_rn[1]}, 32'h09);
        checkOutput("wr_hi_dat", {24'b0, w_dat[1]}, 32'hBE);
        checkOutput("wr_rsp", {16'b0, rsp_data}, 32'hBEEF);
        checkOutput("wr_err", {31'b0, rsp_err}, 32'd0);
        checkOutput("wr_file", {16'b0, file[1]}, 32'hBEEF);

        // READ16 HL
        applyStimulus(2'b01, 3'd2, 16'h5555);
        checkOutput("rd_lat", lat, 32'd2);
        checkOutput("rd_rn_out", {27'b0, rn_out_seen}, 32'h12);
        checkOutput("rd_rsp", {16'b0, rsp_data}, 32'h1234);
        checkOutput("rd_we_cnt", we_cnt, 32'd0);

        // INC16 BC=FFFF wraps, DEC16 SP=0000 wraps
        applyStimulus(2'b10, 3'd0, 16'h0000);
        checkOutput("inc_lat", lat, 32'd4);
        checkOutput("inc_we_cnt", we_cnt, 32'd2);
        checkOutput("inc_lo_dat", {24'b0, w_dat[0]}, 32'h00);
        checkOutput("inc_hi_dat", {24'b0, w_dat[1]}, 32'h00);
        checkOutput("inc_rsp", {16'b0, rsp_data}, 32'h0000);
        checkOutput("inc_file", {16'b0, file[0]}, 32'h0000);
        applyStimulus(2'b11, 3'd3, 16'h0000);
        checkOutput("dec_lat", lat, 32'd4);
        checkOutput("dec_hi_rn", {27'b0, w_rn[1]}, 32'h0B);
        checkOutput("dec_rsp", {16'b0, rsp_data}, 32'hFFFF);
        checkOutput("dec_file", {16'b0, file[3]}, 32'hFFFF);

        // PC step
        applyStimulus(2'b10, 3'd4, 16'h0000);
        checkOutput("pcinc_lat", lat, 32'd2);
        checkOutput("pcinc_we_cnt", we_cnt, 32'd1);
        checkOutput("pcinc_cpc_cnt", cpc_cnt, 32'd1);
        checkOutput("pcinc_dir", {31'b0, inc_seen}, 32'd1);
        checkOutput("pcinc_rn_out", {27'b0, rn_out_seen}, 32'h14);
        checkOutput("pcinc_rsp", {16'b0, rsp_data}, 32'h0101);
        checkOutput("pcinc_file", {16'b0, file[4]}, 32'h0101);
        applyStimulus(2'b11, 3'd4, 16'h0000);
        checkOutput("pcdec_lat", lat, 32'd2);
        checkOutput("pcdec_cpc_cnt", cpc_cnt, 32'd1);
        checkOutput("pcdec_dir", {31'b0, inc_seen}, 32'd0);
        checkOutput("pcdec_rsp", {16'b0, rsp_data}, 32'h0100);

        // Bad register index
        applyStimulus(2'b01, 3'd6, 16'h0000);
        checkOutput("err_lat", lat, 32'd1);
        checkOutput("err_flag", {31'b0, rsp_err}, 32'd1);
        checkOutput("err_rsp", {16'b0, rsp_data}, 32'h0000);
        checkOutput("err_we_cnt", we_cnt, 32'd0);
        checkOutput("err_rn_out", {27'b0, rn_out_seen}, 32'h00);
        repeat (3) @(negedge clock);
        checkOutput("err_held", {31'b0, rsp_err}, 32'd1);
        applyStimulus(2'b01, 3'd1, 16'h0000);
        checkOutput("err_clear", {31'b0, rsp_err}, 32'd0);
        checkOutput("rd_de_rsp", {16'b0, rsp_data}, 32'hBEEF);

        // Reset during WR_HI of WRITE16 HL=ABCD
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_reg   = 3'd2;
        req_data  = 16'hABCD;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        checkOutput("rstmid_wrlo_we", {31'b0, rf_we}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rstmid_we_gated", {31'b0, rf_we}, 32'd0);
        @(negedge clock);
        checkOutput("rstmid_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rstmid_rsp_data", {16'b0, rsp_data}, 32'h0000);
        checkOutput("rstmid_file", {16'b0, file[2]}, 32'h12CD);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rstmid_no_rsp", {31'b0, rsp_valid}, 32'd0);

`ifdef REGSEQ_RESP_HOLD_EN
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_reg   = 3'd1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("hold_valid", {31'b0, rsp_valid}, 32'd1);
            checkOutput("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        checkOutput("hold_data", {16'b0, rsp_data}, 32'hBEEF);
        rsp_ready = 1'b1;
        @(negedge clock);
        checkOutput("hold_release_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("hold_release_ready", {31'b0, req_ready}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
